// File: rtl/gcd_lcm_pkg.sv
// Shared definitions for the GCD/LCM datapath and its controller.
// The state encodings double as the state_o output values.
package gcd_lcm_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_LOADED = 2'd1,
    ST_ERROR  = 2'd2
  } state_t;

  localparam logic [7:0] STEP_COUNT_MAX = 8'd255;

  // True when more than one bit of a one-hot command vector is set.
  function automatic logic multi_hot(input logic [3:0] v);
    return (v & (v - 4'd1)) != 4'd0;
  endfunction

endpackage

// File: rtl/gcd_lcm_datapath.sv
// Working registers x/y with subtract/add steps for GCD (repeated subtraction)
// and LCM (repeated addition of the loaded bases), plus sticky error tracking.
module gcd_lcm_datapath
  import gcd_lcm_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_STEPS = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             load_x,
  input  logic             load_y,
  input  logic             subtract_x,
  input  logic             subtract_y,
  input  logic             add_x,
  input  logic             add_y,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic             x_eq_y,
  output logic             x_gt_y,
  output logic [7:0]       step_count,
  output logic [1:0]       state_o,
  output logic             overflow,
  output logic             zero_err,
  output logic             cmd_err,
  output logic             timeout
);

  state_t           state, state_n;
  logic [WIDTH-1:0] a0, b0;
  logic [WIDTH-1:0] x_n, y_n, a0_n, b0_n;
  logic [7:0]       step_count_n;
  logic             overflow_n, zero_err_n, cmd_err_n, timeout_n;

  logic [3:0]       step_cmds;
  logic             step_any;
  logic             step_ok;

  // One extra bit catches both borrow on subtract and carry on add.
  logic [WIDTH:0]   x_minus_y, y_minus_x, x_plus_a0, y_plus_b0;

  assign step_cmds = {subtract_x, subtract_y, add_x, add_y};
  assign step_any  = |step_cmds;

  assign x_minus_y = {1'b0, x} - {1'b0, y};
  assign y_minus_x = {1'b0, y} - {1'b0, x};
  assign x_plus_a0 = {1'b0, x} + {1'b0, a0};
  assign y_plus_b0 = {1'b0, y} + {1'b0, b0};

  assign x_eq_y  = (x == y);
  assign x_gt_y  = (x > y);
  assign state_o = state;

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    state_n      = state;
    x_n          = x;
    y_n          = y;
    a0_n         = a0;
    b0_n         = b0;
    step_count_n = step_count;
    overflow_n   = overflow;
    zero_err_n   = zero_err;
    cmd_err_n    = cmd_err;
    timeout_n    = timeout;
    step_ok      = 1'b1;

    if (step_any && (multi_hot(step_cmds) || load_x || load_y)) begin
      cmd_err_n = 1'b1;
      state_n   = ST_ERROR;
    end else if (load_x && load_y) begin
      x_n          = a_in;
      a0_n         = a_in;
      y_n          = b_in;
      b0_n         = b_in;
      step_count_n = '0;
      overflow_n   = 1'b0;
      cmd_err_n    = 1'b0;
      timeout_n    = 1'b0;
      zero_err_n   = (a_in == '0) || (b_in == '0);
      state_n      = zero_err_n ? ST_ERROR : ST_LOADED;
    end else if (load_x) begin
      x_n  = a_in;
      a0_n = a_in;
    end else if (load_y) begin
      y_n  = b_in;
      b0_n = b_in;
    end else if (step_any) begin
      unique case (state)
        ST_LOADED: begin
          if (subtract_x) begin
            step_ok = ~x_minus_y[WIDTH];
            if (step_ok) x_n = x_minus_y[WIDTH-1:0];
          end else if (subtract_y) begin
            step_ok = ~y_minus_x[WIDTH];
            if (step_ok) y_n = y_minus_x[WIDTH-1:0];
          end else if (add_x) begin
            step_ok = ~x_plus_a0[WIDTH];
            if (step_ok) x_n = x_plus_a0[WIDTH-1:0];
          end else begin
            step_ok = ~y_plus_b0[WIDTH];
            if (step_ok) y_n = y_plus_b0[WIDTH-1:0];
          end

          if (!step_ok) begin
            overflow_n = 1'b1;
            state_n    = ST_ERROR;
          end else begin
            if (step_count != STEP_COUNT_MAX) step_count_n = step_count + 8'd1;
            // Judged on the post-step values: a step that lands on x==y never times out.
            if (int'(step_count_n) == MAX_STEPS && x_n != y_n) begin
              timeout_n = 1'b1;
              state_n   = ST_ERROR;
            end
          end
        end
        ST_EMPTY: cmd_err_n = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_EMPTY;
      x          <= '0;
      y          <= '0;
      a0         <= '0;
      b0         <= '0;
      step_count <= '0;
      overflow   <= 1'b0;
      zero_err   <= 1'b0;
      cmd_err    <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state      <= state_n;
      x          <= x_n;
      y          <= y_n;
      a0         <= a0_n;
      b0         <= b0_n;
      step_count <= step_count_n;
      overflow   <= overflow_n;
      zero_err   <= zero_err_n;
      cmd_err    <= cmd_err_n;
      timeout    <= timeout_n;
    end
  end

endmodule
